// File: rtl/medfilt_window_gen.sv
// medfilt_window_gen: streaming 3x3 window generator for the median filter.
// Takes a raster-order pixel stream, keeps the two previous lines in line
// buffers and presents each complete 3x3 neighbourhood as nine parallel
// pixels (w1 = top-left ... w9 = bottom-right) behind a single output stage.
// Optional build macro: WINGEN_COORD_EN adds win_col/win_row outputs that
// carry the centre-pixel coordinates of the current window.
module medfilt_window_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PIX_W-1:0]          pix_in,
  input  logic                      pix_valid,
  input  logic                      pix_sof,
  output logic                      pix_ready,
  output logic [PIX_W-1:0]          w1,
  output logic [PIX_W-1:0]          w2,
  output logic [PIX_W-1:0]          w3,
  output logic [PIX_W-1:0]          w4,
  output logic [PIX_W-1:0]          w5,
  output logic [PIX_W-1:0]          w6,
  output logic [PIX_W-1:0]          w7,
  output logic [PIX_W-1:0]          w8,
  output logic [PIX_W-1:0]          w9,
  output logic                      win_valid,
  output logic                      win_last,
`ifdef WINGEN_COORD_EN
  output logic [$clog2(IMG_W)-1:0]  win_col,
  output logic [$clog2(IMG_H)-1:0]  win_row,
`endif
  input  logic                      win_ready
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Line buffers: line1_r holds row r-1, line2_r holds row r-2 (indexed by column).
  logic [PIX_W-1:0] line1_r [IMG_W];
  logic [PIX_W-1:0] line2_r [IMG_W];

  // 3x3 window, row-major: index 0 = top-left, 4 = centre, 8 = bottom-right.
  logic [PIX_W-1:0] win_r [9];

  logic [CW-1:0]    col_r;
  logic [RW-1:0]    row_r;
  logic             win_valid_r;
  logic             win_last_r;

  logic             pix_ready_s;
  logic             accept_s;
  logic [CW-1:0]    cur_col_s;
  logic [RW-1:0]    cur_row_s;
  logic [CW-1:0]    nxt_col_s;
  logic [RW-1:0]    nxt_row_s;
  logic [PIX_W-1:0] top_s;
  logic [PIX_W-1:0] mid_s;
  logic             emit_s;
  logic             last_s;

  // Single output stage: a new pixel may enter whenever the window slot is free or draining.
  assign pix_ready_s = !win_valid_r || win_ready;
  assign accept_s    = pix_valid && pix_ready_s;

  // Position of the incoming pixel; start-of-frame forces it to (0,0).
  always_comb begin
    cur_col_s = col_r;
    cur_row_s = row_r;
    if (pix_sof) begin
      cur_col_s = '0;
      cur_row_s = '0;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
  end

  // Next raster position, wrapping at end of line and end of frame.
  always_comb begin
    nxt_col_s = cur_col_s + CW'(1);
    nxt_row_s = cur_row_s;
    if (cur_col_s == CW'(IMG_W - 1)) begin
      nxt_col_s = '0;
      if (cur_row_s == RW'(IMG_H - 1)) begin
        nxt_row_s = '0;
      end else begin
        nxt_row_s = cur_row_s + RW'(1);
      end
    end else begin
      nxt_col_s = cur_col_s + CW'(1);
      nxt_row_s = cur_row_s;
    end
  end

  // New right-hand window column and the decision whether this pixel completes a window.
  always_comb begin
    top_s  = line2_r[cur_col_s];
    mid_s  = line1_r[cur_col_s];
    emit_s = accept_s && (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
    last_s = (cur_row_s == RW'(IMG_H - 1)) && (cur_col_s == CW'(IMG_W - 1));
  end

  // Raster counters advance on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
    end
  end

  // Line buffers roll down one row per accepted pixel; contents are never
  // observed before being rewritten, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line2_r[cur_col_s] <= line1_r[cur_col_s];
      line1_r[cur_col_s] <= pix_in;
    end
  end

  // Window shifts left and takes the new column on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= '0;
      end
    end else if (accept_s) begin
      win_r[0] <= win_r[1];
      win_r[1] <= win_r[2];
      win_r[2] <= top_s;
      win_r[3] <= win_r[4];
      win_r[4] <= win_r[5];
      win_r[5] <= mid_s;
      win_r[6] <= win_r[7];
      win_r[7] <= win_r[8];
      win_r[8] <= pix_in;
    end
  end

  // Output handshake: load on a completing pixel, drop after consumption, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
    end else if (accept_s) begin
      win_valid_r <= emit_s;
      win_last_r  <= emit_s && last_s;
    end else if (win_ready) begin
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
    end
  end

`ifdef WINGEN_COORD_EN
  logic [CW-1:0] win_col_r;
  logic [RW-1:0] win_row_r;

  // Centre-pixel coordinates captured together with each emitted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_col_r <= '0;
      win_row_r <= '0;
    end else if (emit_s) begin
      win_col_r <= cur_col_s - CW'(1);
      win_row_r <= cur_row_s - RW'(1);
    end
  end

  assign win_col = win_col_r;
  assign win_row = win_row_r;
`endif

  assign pix_ready = pix_ready_s;
  assign w1        = win_r[0];
  assign w2        = win_r[1];
  assign w3        = win_r[2];
  assign w4        = win_r[3];
  assign w5        = win_r[4];
  assign w6        = win_r[5];
  assign w7        = win_r[6];
  assign w8        = win_r[7];
  assign w9        = win_r[8];
  assign win_valid = win_valid_r;
  assign win_last  = win_last_r;

endmodule

// File: doc/medfilt_window_gen.md
Name: medfilt_window_gen

Overview:
- Streaming 3x3 window generator that feeds the median filter core.
- Accepts a raster-order pixel stream (one pixel per handshake), buffers two previous image lines, and emits complete 3x3 neighbourhoods as nine parallel pixels.
- Output ordering matches the filter's nine inputs directly.
- Sits upstream of medianFilter: it is the producer of the nine-pixel window that the filter consumes.

Parameters:
- PIX_W, 8, bits per pixel
- IMG_W, 16, pixels per line (>=3)
- IMG_H, 16, lines per frame (>=3)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_in  in  PIX_W  input pixel
- pix_valid  in  1  pix_in valid
- pix_sof  in  1  qualifies pix_in as pixel (0,0) of a new frame
- pix_ready  out  1  block can accept pix_in this cycle
- w1..w9  out  PIX_W each  window, row-major: w1 = top-left, w5 = centre, w9 = bottom-right
- win_valid  out  1  w1..w9 hold a valid window
- win_last  out  1  current window is the last of the frame
- win_ready  in  1  downstream accepts window

Behaviour:
- Reset (async, rst_n low): w1..w9 = 0, win_valid = 0, win_last = 0, row/col counters = 0, window registers = 0. Line-buffer contents are don't-care and are never output before being rewritten.
- pix_ready = !win_valid || win_ready (single output stage, combinational ready).
- Pixel accepted when pix_valid && pix_ready. Nothing changes on non-accept cycles.
- On an accepted pixel at (row r, col c):
  - Window columns shift left.
  - New right column = {line_r-2[c], line_r-1[c], pix_in}.
  - line_r-2[c] <= line_r-1[c]; line_r-1[c] <= pix_in.
  - col increments; at col == IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both row and col wrap to 0.
- Window emission:
  - If r >= 2 and c >= 2, the next cycle has win_valid = 1 and w1..w9 = neighbourhood centred at (r-1, c-1). Latency is 1 clock from acceptance.
  - Windows straddling a line wrap (c < 2) are never emitted.
  - Emits (IMG_W-2)*(IMG_H-2) windows per frame.
- win_last = 1 with the window generated from pixel (IMG_H-1, IMG_W-1); otherwise 0.
- win_valid handshake:
  - Falls after win_valid && win_ready unless a new window is produced the same cycle (back-to-back allowed).
  - While win_valid && !win_ready: w1..w9, win_valid and win_last are held stable, and pix_ready = 0.
- pix_sof:
  - If asserted on an accepted pixel, that pixel is forced to (0,0) regardless of counters. Any partial frame is abandoned; no window is emitted for it.
  - A pending unaccepted output window is unaffected.
  - pix_sof on a non-accepted cycle is ignored.
- The first frame after reset needs no pix_sof; counters start at (0,0).
- Reset mid-frame: immediate clear as above. The next accepted pixel is (0,0).
- Counter widths: clog2(IMG_W) and clog2(IMG_H). Values beyond IMG_W-1 / IMG_H-1 are unreachable.

Optional Feature:
- Macro: WINGEN_COORD_EN.
- Defined: adds output ports win_col (clog2(IMG_W) bits) and win_row (clog2(IMG_H) bits) holding the centre-pixel coordinates of the current window. Reset 0. Held with w1..w9 under backpressure.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
- IMG_W = IMG_H = 4, pixel(r,c) = 16r+c, pix_valid = 1, win_ready = 1:
  - -> exactly 4 windows.
  - First: w1..w9 = 00,01,02,10,11,12,20,21,22, one clock after (2,2) is accepted.
  - Last: 11,12,13,21,22,23,31,32,33 with win_last = 1.
- Same stream, win_ready = 0 for 5 cycles after the first window -> window held unchanged, pix_ready = 0, no pixel lost. Remaining windows correct after release.
- Same stream, pix_valid toggling 1/0 every cycle -> identical window sequence, no duplicates.
- Assert pix_sof with value 0xAA at pixel (1,3) of frame 1 -> no window from the partial frame. Next windows computed with 0xAA as (0,0) of the new frame.
- Assert rst_n low for 1 cycle after pixel (2,2) is accepted -> all outputs 0 immediately. A fresh 4x4 frame then yields the 4 correct windows.
- Connect the medianFilter core; IMG_W = IMG_H = 4; pixel(r,c) = 16r+c -> medians 0x11, 0x12, 0x21, 0x22.
